// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame FSM states, scan-code
// prefixes and the Tetris key codes the cpu looks for.
package ps2_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StData   = 2'd1,
    StParity = 2'd2,
    StStop   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // Arrow keys arrive with the E0 prefix; space does not.
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_SPACE = 8'h29;

  typedef struct packed {
    logic [7:0] code;
    logic       brk;
    logic       ext;
  } key_event_t;

  // True when the vector holds an odd number of ones.
  function automatic logic odd_ones(input logic [8:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronises the raw PS/2 lines into the clock domain and emits a registered
// one-cycle pulse on each PS2Clk falling edge, together with the data bit at that edge.
module ps2_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall_pulse,
  output logic data_sampled
);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic                   fall_q, fall_d;
  logic                   data_q, data_d;

  always_comb begin
    clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data};
    clk_prev_d  = clk_sync_q[SYNC_STAGES-1];
    fall_d      = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
    data_d      = data_sync_q[SYNC_STAGES-1];
  end

  // Idle level of both PS/2 lines is high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      fall_q      <= 1'b0;
      data_q      <= 1'b1;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      fall_q      <= fall_d;
      data_q      <= data_d;
    end
  end

  assign fall_pulse   = fall_q;
  assign data_sampled = data_q;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 device-to-host receiver: deframes 11-bit frames, folds E0/F0 prefixes into
// key events and holds the latest event in a one-entry mailbox for the cpu.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  input  logic       key_ack,
  output logic [7:0] key_code,
  output logic       key_break,
  output logic       key_ext,
  output logic       key_pending,
  output logic       key_overrun,
  output logic       frame_error
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

  logic fall;
  logic din;

  ps2_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clock        (clock),
    .reset        (reset),
    .ps2_clk      (PS2Clk),
    .ps2_data     (PS2Data),
    .fall_pulse   (fall),
    .data_sampled (din)
  );

  ps2_state_e      state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            parity_q, parity_d;
  logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic            ext_flag_q, ext_flag_d;
  logic            brk_flag_q, brk_flag_d;
  logic [7:0]      key_code_q, key_code_d;
  logic            key_break_q, key_break_d;
  logic            key_ext_q, key_ext_d;
  logic            key_pending_q, key_pending_d;
  logic            key_overrun_q, key_overrun_d;
  logic            frame_error_q, frame_error_d;
  logic            byte_done;
  logic            key_event;

  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    parity_d      = parity_q;
    tmo_cnt_d     = tmo_cnt_q;
    ext_flag_d    = ext_flag_q;
    brk_flag_d    = brk_flag_q;
    key_code_d    = key_code_q;
    key_break_d   = key_break_q;
    key_ext_d     = key_ext_q;
    key_pending_d = key_pending_q;
    key_overrun_d = 1'b0;
    frame_error_d = 1'b0;
    byte_done     = 1'b0;
    key_event     = 1'b0;

    if (fall) begin
      tmo_cnt_d = '0;
      unique case (state_q)
        StIdle: begin
          if (!din) begin
            state_d   = StData;
            bit_cnt_d = 3'd0;
          end else begin
            frame_error_d = 1'b1;
          end
        end
        StData: begin
          shift_d   = {din, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = StParity;
          end
        end
        StParity: begin
          parity_d = din;
          state_d  = StStop;
        end
        StStop: begin
          state_d = StIdle;
          if (din && odd_ones({shift_q, parity_q})) begin
            byte_done = 1'b1;
          end else begin
            frame_error_d = 1'b1;
            ext_flag_d    = 1'b0;
            brk_flag_d    = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle) begin
      // A stalled keyboard must not leave the FSM stuck mid-frame.
      if (tmo_cnt_q == CntMax) begin
        state_d       = StIdle;
        tmo_cnt_d     = '0;
        frame_error_d = 1'b1;
        ext_flag_d    = 1'b0;
        brk_flag_d    = 1'b0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
    end

    if (byte_done) begin
      if (shift_q == PS2_EXT) begin
        ext_flag_d = 1'b1;
      end else if (shift_q == PS2_BRK) begin
        brk_flag_d = 1'b1;
      end else begin
        key_event  = 1'b1;
        ext_flag_d = 1'b0;
        brk_flag_d = 1'b0;
      end
    end

    // A new event beats a simultaneous ack and only counts as overrun if unacked.
    if (key_event) begin
      key_code_d    = shift_q;
      key_break_d   = brk_flag_q;
      key_ext_d     = ext_flag_q;
      key_pending_d = 1'b1;
      key_overrun_d = key_pending_q & ~key_ack;
    end else if (key_ack) begin
      key_pending_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      parity_q      <= 1'b0;
      tmo_cnt_q     <= '0;
      ext_flag_q    <= 1'b0;
      brk_flag_q    <= 1'b0;
      key_code_q    <= '0;
      key_break_q   <= 1'b0;
      key_ext_q     <= 1'b0;
      key_pending_q <= 1'b0;
      key_overrun_q <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      parity_q      <= parity_d;
      tmo_cnt_q     <= tmo_cnt_d;
      ext_flag_q    <= ext_flag_d;
      brk_flag_q    <= brk_flag_d;
      key_code_q    <= key_code_d;
      key_break_q   <= key_break_d;
      key_ext_q     <= key_ext_d;
      key_pending_q <= key_pending_d;
      key_overrun_q <= key_overrun_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign key_code    = key_code_q;
  assign key_break   = key_break_q;
  assign key_ext     = key_ext_q;
  assign key_pending = key_pending_q;
  assign key_overrun = key_overrun_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: directed vector table, timeout and reset
// sequences, then random frames checked against a byte-level reference model.
module tb_ps2_keyboard_rx;
  import ps2_pkg::*;

  localparam int unsigned TMO = 200;
  localparam int KOk    = 0;
  localparam int KPar   = 1;
  localparam int KStop  = 2;
  localparam int KStart = 3;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       PS2Clk = 1'b1;
  logic       PS2Data = 1'b1;
  logic       key_ack = 1'b0;
  logic [7:0] key_code;
  logic       key_break, key_ext, key_pending, key_overrun, frame_error;

  ps2_keyboard_rx #(
    .TIMEOUT_CYCLES (TMO),
    .SYNC_STAGES    (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .PS2Clk      (PS2Clk),
    .PS2Data     (PS2Data),
    .key_ack     (key_ack),
    .key_code    (key_code),
    .key_break   (key_break),
    .key_ext     (key_ext),
    .key_pending (key_pending),
    .key_overrun (key_overrun),
    .frame_error (frame_error)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;
  int err_seen = 0;
  int ovr_seen = 0;

  always @(negedge clock) begin
    if (frame_error) err_seen++;
    if (key_overrun) ovr_seen++;
  end

  typedef struct {
    logic [7:0] data;
    int         kind;
    bit         ack_sync;
    bit         ack_after;
    logic [7:0] code;
    bit         brk;
    bit         ext;
    bit         pend;
    int         err;
    int         ovr;
  } vec_t;

  vec_t tbl[$];

  // Reference model state: mailbox contents and pending prefixes.
  logic [7:0] m_code;
  bit         m_brk, m_ext, m_pend, m_extf, m_brkf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_glitch();
    PS2Data = 1'b1;
    repeat (10) @(negedge clock);
    PS2Clk = 1'b0;
    repeat (10) @(negedge clock);
    PS2Clk = 1'b1;
    repeat (20) @(negedge clock);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      PS2Data = bits[i];
      repeat (10) @(negedge clock);
      PS2Clk = 1'b0;
      repeat (10) @(negedge clock);
      PS2Clk = 1'b1;
    end
    PS2Data = 1'b1;
  endtask

  // ack_sync raises key_ack in the exact cycle the stop-bit edge is processed.
  task automatic send_frame(input logic [7:0] d, input int kind, input bit ack_sync);
    logic [10:0] bits;
    logic        par;
    if (kind == KStart) begin
      send_glitch();
    end else begin
      par = ~(^d);
      if (kind == KPar) par = ~par;
      bits = {(kind == KStop) ? 1'b0 : 1'b1, par, d, 1'b0};
      for (int i = 0; i < 11; i++) begin
        PS2Data = bits[i];
        repeat (10) @(negedge clock);
        PS2Clk = 1'b0;
        if (i == 10 && ack_sync) begin
          repeat (3) @(negedge clock);
          key_ack = 1'b1;
          @(negedge clock);
          key_ack = 1'b0;
          repeat (6) @(negedge clock);
        end else begin
          repeat (10) @(negedge clock);
        end
        PS2Clk = 1'b1;
      end
      PS2Data = 1'b1;
      repeat (20) @(negedge clock);
    end
  endtask

  task automatic do_ack();
    key_ack = 1'b1;
    @(negedge clock);
    key_ack = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic model_frame(input logic [7:0] d, input int kind, input bit ack_sync,
                             output int de, output int dov);
    bit ev;
    de  = 0;
    dov = 0;
    ev  = 1'b0;
    if (kind != KOk) begin
      de = 1;
      m_extf = 1'b0;
      m_brkf = 1'b0;
    end else if (d == PS2_EXT) begin
      m_extf = 1'b1;
    end else if (d == PS2_BRK) begin
      m_brkf = 1'b1;
    end else begin
      ev = 1'b1;
    end
    if (ev) begin
      if (m_pend && !ack_sync) dov = 1;
      m_code = d;
      m_brk  = m_brkf;
      m_ext  = m_extf;
      m_pend = 1'b1;
      m_extf = 1'b0;
      m_brkf = 1'b0;
    end else if (ack_sync) begin
      m_pend = 1'b0;
    end
  endtask

  task automatic check_outputs(input string tag, input logic [7:0] code, input bit brk,
                               input bit ext, input bit pend);
    check({tag, ".code"}, 32'(key_code), 32'(code));
    check({tag, ".break"}, 32'(key_break), 32'(brk));
    check({tag, ".ext"}, 32'(key_ext), 32'(ext));
    check({tag, ".pending"}, 32'(key_pending), 32'(pend));
  endtask

  initial begin
    int e0, o0, de, dov;
    logic [7:0] d;
    int kind;
    bit async, aafter;

    // Table: {data, kind, ack_sync, ack_after, code, brk, ext, pend, err, ovr}
    tbl.push_back('{8'h1C, KOk, 0, 1, 8'h1C, 0, 0, 1, 0, 0});
    tbl.push_back('{PS2_BRK, KOk, 0, 0, 8'h1C, 0, 0, 0, 0, 0});
    tbl.push_back('{8'h1C, KOk, 0, 1, 8'h1C, 1, 0, 1, 0, 0});
    tbl.push_back('{PS2_EXT, KOk, 0, 0, 8'h1C, 1, 0, 0, 0, 0});
    tbl.push_back('{KEY_UP, KOk, 0, 1, KEY_UP, 0, 1, 1, 0, 0});
    tbl.push_back('{PS2_EXT, KOk, 0, 0, KEY_UP, 0, 1, 0, 0, 0});
    tbl.push_back('{PS2_BRK, KOk, 0, 0, KEY_UP, 0, 1, 0, 0, 0});
    tbl.push_back('{KEY_UP, KOk, 0, 1, KEY_UP, 1, 1, 1, 0, 0});
    tbl.push_back('{8'h1C, KPar, 0, 0, KEY_UP, 1, 1, 0, 1, 0});
    tbl.push_back('{PS2_EXT, KOk, 0, 0, KEY_UP, 1, 1, 0, 0, 0});
    tbl.push_back('{8'h55, KStop, 0, 0, KEY_UP, 1, 1, 0, 1, 0});
    tbl.push_back('{8'h1C, KOk, 0, 1, 8'h1C, 0, 0, 1, 0, 0});
    tbl.push_back('{KEY_LEFT, KOk, 0, 0, KEY_LEFT, 0, 0, 1, 0, 0});
    tbl.push_back('{KEY_LEFT, KOk, 0, 0, KEY_LEFT, 0, 0, 1, 0, 1});
    tbl.push_back('{PS2_EXT, KOk, 0, 0, KEY_LEFT, 0, 0, 1, 0, 0});
    tbl.push_back('{KEY_LEFT, KOk, 1, 1, KEY_LEFT, 0, 1, 1, 0, 0});
    tbl.push_back('{KEY_RIGHT, KOk, 0, 0, KEY_RIGHT, 0, 0, 1, 0, 0});
    tbl.push_back('{8'h00, KStart, 0, 1, KEY_RIGHT, 0, 0, 1, 1, 0});

    // Reset state
    @(negedge clock);
    #1;
    check_outputs("reset", 8'h00, 0, 0, 0);
    check("reset.overrun", 32'(key_overrun), 32'd0);
    check("reset.frame_error", 32'(frame_error), 32'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    foreach (tbl[i]) begin
      e0 = err_seen;
      o0 = ovr_seen;
      send_frame(tbl[i].data, tbl[i].kind, tbl[i].ack_sync);
      check_outputs($sformatf("vec%0d", i), tbl[i].code, tbl[i].brk, tbl[i].ext, tbl[i].pend);
      check($sformatf("vec%0d.frame_error", i), 32'(err_seen - e0), 32'(tbl[i].err));
      check($sformatf("vec%0d.overrun", i), 32'(ovr_seen - o0), 32'(tbl[i].ovr));
      if (tbl[i].ack_after) begin
        do_ack();
        check($sformatf("vec%0d.ack_pending", i), 32'(key_pending), 32'd0);
        check($sformatf("vec%0d.ack_code", i), 32'(key_code), 32'(tbl[i].code));
      end
    end

    // Timeout: start + 4 data bits, then silence.
    e0 = err_seen;
    send_bits(11'b000_0000_1010, 5);
    repeat (170) @(negedge clock);
    check("timeout.early", 32'(err_seen - e0), 32'd0);
    repeat (60) @(negedge clock);
    check("timeout.pulse", 32'(err_seen - e0), 32'd1);
    check("timeout.pending", 32'(key_pending), 32'd0);
    send_frame(KEY_SPACE, KOk, 0);
    check_outputs("after_timeout", KEY_SPACE, 0, 0, 1);
    check("after_timeout.frame_error", 32'(err_seen - e0), 32'd1);

    // Reset in the middle of a frame while a key is pending.
    e0 = err_seen;
    send_bits(11'b100_1010_1010, 5);
    reset = 1'b1;
    #1;
    check_outputs("mid_reset", 8'h00, 0, 0, 0);
    repeat (3) @(negedge clock);
    PS2Clk  = 1'b1;
    PS2Data = 1'b1;
    reset   = 1'b0;
    repeat (300) @(negedge clock);
    check("mid_reset.no_pulse", 32'(err_seen - e0), 32'd0);
    send_frame(PS2_EXT, KOk, 0);
    send_frame(KEY_DOWN, KOk, 0);
    check_outputs("post_reset", KEY_DOWN, 0, 1, 1);
    do_ack();

    // Random frames against the reference model.
    m_code = KEY_DOWN;
    m_brk  = 1'b0;
    m_ext  = 1'b1;
    m_pend = 1'b0;
    m_extf = 1'b0;
    m_brkf = 1'b0;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0, 1: d = PS2_EXT;
        2:    d = PS2_BRK;
        3:    d = KEY_LEFT;
        4:    d = KEY_RIGHT;
        5:    d = KEY_UP;
        6:    d = KEY_DOWN;
        7:    d = KEY_SPACE;
        default: d = 8'($urandom);
      endcase
      case ($urandom_range(0, 9))
        0:       kind = KPar;
        1:       kind = KStop;
        default: kind = KOk;
      endcase
      async  = ($urandom_range(0, 4) == 0);
      aafter = ($urandom_range(0, 2) == 0);
      e0 = err_seen;
      o0 = ovr_seen;
      send_frame(d, kind, async);
      model_frame(d, kind, async, de, dov);
      check_outputs($sformatf("rnd%0d", n), m_code, m_brk, m_ext, m_pend);
      check($sformatf("rnd%0d.frame_error", n), 32'(err_seen - e0), 32'(de));
      check($sformatf("rnd%0d.overrun", n), 32'(ovr_seen - o0), 32'(dov));
      if (aafter) begin
        do_ack();
        m_pend = 1'b0;
        check($sformatf("rnd%0d.ack_pending", n), 32'(key_pending), 32'(m_pend));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
Upstream input stage for the Tetris cpu. It receives raw PS2Clk/PS2Data from the keyboard, deframes 11-bit PS/2 device-to-host frames and folds E0/F0 prefixes into single key events. Each event is held in a one-entry mailbox that the cpu datapath reads and acknowledges. Runs entirely in the cpu clock domain; the PS/2 lines are treated as asynchronous inputs.

Parameters:
- TIMEOUT_CYCLES, 100000: clock cycles allowed between PS/2 falling edges inside a frame (2 ms at 50 MHz) before the frame is aborted.
- SYNC_STAGES, 2: flip-flop stages on each PS/2 input; minimum 2.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- PS2Clk, input, 1: raw keyboard clock line.
- PS2Data, input, 1: raw keyboard data line.
- key_ack, input, 1: one-cycle pulse from the cpu; clears key_pending.
- key_code, output, 8: scan code of the last event, with prefixes stripped.
- key_break, output, 1: the event was a release (preceded by F0).
- key_ext, output, 1: the event was extended (preceded by E0).
- key_pending, output, 1: mailbox full; key_code, key_break and key_ext are valid and stable.
- key_overrun, output, 1: one-cycle pulse when a new event overwrites an unacknowledged one.
- frame_error, output, 1: one-cycle pulse on a start, parity, stop or timeout error.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs go to 0; FSM to IDLE; prefix flags, shift register and timeout counter to 0.
  - Synchroniser flops reset to 1, the PS/2 idle level.
  - Reset asserted mid-frame discards the partial frame; no pulse is emitted.
- Input conditioning:
  - PS2Clk and PS2Data pass through SYNC_STAGES flops.
  - A falling edge is sync_clk_prev=1 and sync_clk=0, registered once.
  - PS2Data is sampled on the same cycle the edge is detected.
- Frame FSM, states IDLE, DATA, PARITY, STOP. All transitions happen only on a detected falling edge, except timeout.
  - IDLE: sampled data 0 (start bit) moves to DATA with bit count 0. Sampled data 1 causes a frame_error pulse and the FSM stays in IDLE.
  - DATA: shifts in LSB first. After the 8th bit, moves to PARITY.
  - PARITY: stores the parity bit. Total ones across data plus parity must be odd; the check is performed in STOP.
  - STOP: requires stop bit 1 and correct parity for a byte-complete event; then returns to IDLE. On any failure, frame_error pulses, prefix flags clear, and the FSM goes to IDLE.
- Timeout:
  - In any state other than IDLE, the counter increments each cycle and resets on every falling edge.
  - When it reaches TIMEOUT_CYCLES-1, the FSM goes to IDLE, frame_error pulses, and prefix flags clear.
  - Counter width is clog2(TIMEOUT_CYCLES).
- Prefix folding on byte-complete:
  - 0xE0 sets ext_flag.
  - 0xF0 sets brk_flag.
  - Any other byte produces a key event carrying {byte, brk_flag, ext_flag}, after which both flags clear.
  - Prefixes alone never set key_pending.
- Mailbox:
  - On the cycle after a key event, key_code, key_break and key_ext load and key_pending goes to 1. Latency is 1 cycle from the stop-bit edge-detect cycle.
  - key_ack while pending clears key_pending next cycle; outputs hold their values.
  - A key event while pending overwrites the outputs, pulses key_overrun, and keeps pending at 1.
  - A key event and key_ack in the same cycle: the event wins, pending stays 1, and there is no overrun.
  - key_ack while not pending is ignored.
- Pulses (key_overrun, frame_error) are exactly one clock wide and registered.

Decomposition:
- Shared package ps2_pkg holds:
  - FSM state encoding (IDLE, DATA, PARITY, STOP).
  - Scan-code constants PS2_EXT=8'hE0 and PS2_BRK=8'hF0.
  - Tetris key codes: LEFT=8'h6B, RIGHT=8'h74, UP=8'h75, DOWN=8'h72 (all with ext), SPACE=8'h29.
- One sub-module, ps2_sync_edge: the synchroniser plus falling-edge detector. It outputs fall_pulse and data_sampled.

Test Plan:
- Frame 0x1C (start 0, data LSB first, parity 0, stop 1) -> key_pending=1, key_code=1C, key_break=0, key_ext=0; key_ack pulse -> key_pending=0 with code held.
- Frames F0 then 1C -> exactly one event: code=1C, break=1, ext=0; no pending after the F0 frame alone.
- Frames E0 75, then E0 F0 75 with key_ack between -> {75,0,1}, then {75,1,1}.
- 0x1C sent with parity 1 -> one frame_error pulse, no pending; the following E0 prefix is cleared by a forced error, then 1C arrives as {1C,0,0}.
- 5 bits sent then silence with TIMEOUT_CYCLES=200 -> frame_error pulses 200 cycles after the last edge, FSM in IDLE; the next clean 0x29 frame is received correctly.
- Edge cases:
  - Second 0x6B sent without ack -> key_overrun pulse, code=6B.
  - Event coinciding with key_ack -> pending stays 1, no overrun.
  - Reset asserted mid-frame -> all outputs 0 immediately.
